fpu_scoreboard: RTL and testbench
=================================

FPU_SCOREBOARD -- requirements
Module: fpu_scoreboard

Interface
REQ-001 Parameter DEPTH, default 3: number of FP pipeline stages tracked (2..8).
REQ-002 Parameter DIV_LAT, default 4: cycles a div/sqrt result occupies stage 0 (1..63).
REQ-003 Parameter RW, default 5: FP register address width.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 id_valid  in  1  decode stage holds an FP-pipeline instruction requesting issue.
REQ-007 id_fs, id_ft, id_fd  in  RW each  source and destination FP register numbers.
REQ-008 id_use_fs, id_use_ft  in  1 each  instruction reads fs / ft.
REQ-009 id_wr  in  1  instruction writes id_fd at pipeline exit.
REQ-010 id_ds  in  1  instruction is fdiv or fsqrt.
REQ-011 stall  out  1  issue blocked this cycle (hazard or div/sqrt hold).
REQ-012 stall_ds  out  1  stage 0 held by div/sqrt.
REQ-013 fwd_fs, fwd_ft  out  1 each  operand taken from last-stage result.
REQ-014 wb_valid  out  1, wb_rn  out  RW  retiring write in stage DEPTH-1.
REQ-015 occ  out  4  count of valid entries in stages 0..DEPTH-1.

Function
REQ-016 State: per stage k, {v[k], ds[k], rn[k]}; hold counter hcnt, 6 bits.
REQ-017 Stage 0 advances when hcnt==0; stages 1..DEPTH-1 shift every cycle.
REQ-018 Stage 1 receives a bubble (v=0) while stage 0 is held.
REQ-019 match(k,r) = v[k] & (rn[k]==r); register 0 is a real FP register, no zero exclusion.
REQ-020 haz = id_use_fs & any match(k,id_fs) for k in 0..DEPTH-2, OR the same for ft.
REQ-021 stall_ds = v[0] & ds[0] & (hcnt!=0).
REQ-022 stall = id_valid & (haz | stall_ds); combinational, same cycle.
REQ-023 issue = id_valid & ~stall; on issue, at the next edge stage 0 loads {id_wr, id_ds, id_fd}.
REQ-024 On issue with id_ds=1, hcnt loads DIV_LAT-1; otherwise, while hcnt!=0, hcnt decrements by 1.
REQ-025 With no issue and stage 0 advancing, stage 0 loads a bubble.
REQ-026 Divide timing: a div/sqrt stays in stage 0 for exactly DIV_LAT cycles, then enters stage 1.
REQ-027 Issue is permitted in the cycle hcnt==0, even when ds[0]=1.
REQ-028 fwd_fs = id_use_fs & match(DEPTH-1,id_fs); fwd_ft likewise; both gated by id_valid.
REQ-029 When several stages match, the youngest (lowest k) decides; any match in 0..DEPTH-2 stalls regardless of an older last-stage match.
REQ-030 wb_valid = v[DEPTH-1]; wb_rn = rn[DEPTH-1].
REQ-031 occ = popcount of v[0..DEPTH-1], registered-state derived.
REQ-032 Issue and retire in the same cycle are both honoured.

Reset
REQ-033 rst asserted: all v, ds, rn cleared; hcnt=0; immediately stall=0 (with id_valid=0), wb_valid=0, occ=0.
REQ-034 Reset during a div/sqrt hold abandons it; first post-reset edge behaves as from idle.

Configuration
REQ-035 Macro FPU_SB_FWD_EN defined: behaviour as above.
REQ-036 FPU_SB_FWD_EN undefined: fwd_fs=fwd_ft=0, and the hazard range in REQ-020 extends to k=0..DEPTH-1.

Verification (DEPTH=3, DIV_LAT=4, FPU_SB_FWD_EN defined unless stated)
REQ-037 Issue fadd fd=5, next cycle fs=5 -> stall=1 for 2 cycles, then fwd_fs=1 with stall=0.
REQ-038 Issue fdiv fd=7, then a stream of independent ops -> stall_ds=1 for 3 cycles; next op issues on cycle 4; wb_valid with wb_rn=7 appears 6 cycles after the fdiv issue.
REQ-039 fd=3 in stage 2 and fd=3 in stage 0, consumer fs=3 -> stall=1 and fwd_fs=0.
REQ-040 FPU_SB_FWD_EN undefined: same as REQ-037 -> stall=1 for 3 cycles, fwd_fs never asserted.
REQ-041 rst pulsed during fdiv hold (hcnt=2) -> occ=0, stall_ds=0 immediately; next fdiv holds the full 4 cycles.
REQ-042 Back-to-back independent issues for 10 cycles -> occ saturates at 3, wb_valid continuous from cycle 3.

Source files
------------

// File: rtl/fpu_scoreboard_if.sv
// Decode-to-scoreboard bundle: issue request and operand info from decode, hazard/forward/retire status back.
// RW sets the FP register address width.
interface fpu_scoreboard_if #(
    parameter int RW = 5
) ();
    logic          id_valid;
    logic [RW-1:0] id_fs;
    logic [RW-1:0] id_ft;
    logic [RW-1:0] id_fd;
    logic          id_use_fs;
    logic          id_use_ft;
    logic          id_wr;
    logic          id_ds;
    logic          stall;
    logic          stall_ds;
    logic          fwd_fs;
    logic          fwd_ft;
    logic          wb_valid;
    logic [RW-1:0] wb_rn;
    logic [3:0]    occ;

    modport master (
        output id_valid, id_fs, id_ft, id_fd, id_use_fs, id_use_ft, id_wr, id_ds,
        input  stall, stall_ds, fwd_fs, fwd_ft, wb_valid, wb_rn, occ
    );

    modport slave (
        input  id_valid, id_fs, id_ft, id_fd, id_use_fs, id_use_ft, id_wr, id_ds,
        output stall, stall_ds, fwd_fs, fwd_ft, wb_valid, wb_rn, occ
    );
endinterface

// File: rtl/fpu_scoreboard.sv
// FP pipeline scoreboard: RAW hazard stall, div/sqrt stage-0 hold, last-stage forwarding, writeback tracking.
// Macro FPU_SB_FWD_EN enables forwarding from stage DEPTH-1; otherwise that stage also stalls.
module fpu_scoreboard #(
    parameter int DEPTH   = 3,
    parameter int DIV_LAT = 4,
    parameter int RW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    fpu_scoreboard_if.slave sb
);
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ds;
    logic [RW-1:0]    rn [DEPTH];
    logic [5:0]       hcnt;

    logic advance;
    logic issue;
    logic haz;
    logic young_fs;
    logic young_ft;
    logic last_fs;
    logic last_ft;
    logic [3:0] occ_cnt;

    assign advance = (hcnt == 6'd0);

    // Stages 0..DEPTH-2 are never forwardable; the last stage is checked separately.
    always_comb begin
        young_fs = 1'b0;
        young_ft = 1'b0;
        for (int k = 0; k < DEPTH-1; k++) begin
            if (v[k] && (rn[k] == sb.id_fs)) young_fs = 1'b1;
            if (v[k] && (rn[k] == sb.id_ft)) young_ft = 1'b1;
        end
    end

    assign last_fs = v[DEPTH-1] && (rn[DEPTH-1] == sb.id_fs);
    assign last_ft = v[DEPTH-1] && (rn[DEPTH-1] == sb.id_ft);

`ifdef FPU_SB_FWD_EN
    assign haz       = (sb.id_use_fs & young_fs) | (sb.id_use_ft & young_ft);
    assign sb.fwd_fs = sb.id_valid & sb.id_use_fs & last_fs & ~young_fs;
    assign sb.fwd_ft = sb.id_valid & sb.id_use_ft & last_ft & ~young_ft;
`else
    assign haz       = (sb.id_use_fs & (young_fs | last_fs)) |
                       (sb.id_use_ft & (young_ft | last_ft));
    assign sb.fwd_fs = 1'b0;
    assign sb.fwd_ft = 1'b0;
`endif

    assign sb.stall_ds = v[0] & ds[0] & (hcnt != 6'd0);
    assign sb.stall    = sb.id_valid & (haz | sb.stall_ds);
    assign issue       = sb.id_valid & ~sb.stall;

    always_comb begin
        occ_cnt = 4'd0;
        for (int k = 0; k < DEPTH; k++) occ_cnt = occ_cnt + 4'(v[k]);
    end

    assign sb.occ      = occ_cnt;
    assign sb.wb_valid = v[DEPTH-1];
    assign sb.wb_rn    = rn[DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v    <= '0;
            ds   <= '0;
            hcnt <= 6'd0;
            for (int k = 0; k < DEPTH; k++) rn[k] <= '0;
        end else begin
            // Stage 1 takes a bubble while stage 0 is held by a div/sqrt.
            if (advance) begin
                v[1]  <= v[0];
                ds[1] <= ds[0];
                rn[1] <= rn[0];
            end else begin
                v[1]  <= 1'b0;
                ds[1] <= 1'b0;
                rn[1] <= '0;
            end
            for (int k = 2; k < DEPTH; k++) begin
                v[k]  <= v[k-1];
                ds[k] <= ds[k-1];
                rn[k] <= rn[k-1];
            end

            if (issue) begin
                v[0]  <= sb.id_wr;
                ds[0] <= sb.id_ds;
                rn[0] <= sb.id_fd;
            end else if (advance) begin
                v[0]  <= 1'b0;
                ds[0] <= 1'b0;
                rn[0] <= '0;
            end

            if (issue && sb.id_ds) hcnt <= 6'(DIV_LAT - 1);
            else if (hcnt != 6'd0) hcnt <= hcnt - 6'd1;
        end
    end
endmodule

// File: tb/tb_fpu_scoreboard.sv
// Directed bench for fpu_scoreboard (DEPTH=3, DIV_LAT=4); expectations follow FPU_SB_FWD_EN.
module tb_fpu_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fpu_scoreboard_if #(.RW(5)) sbi ();

    fpu_scoreboard #(.DEPTH(3), .DIV_LAT(4), .RW(5)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic vld, input logic [4:0] fs, input logic [4:0] ft,
                          input logic [4:0] fd, input logic ufs, input logic uft,
                          input logic wr, input logic dsv);
        sbi.id_valid  = vld;
        sbi.id_fs     = fs;
        sbi.id_ft     = ft;
        sbi.id_fd     = fd;
        sbi.id_use_fs = ufs;
        sbi.id_use_ft = uft;
        sbi.id_wr     = wr;
        sbi.id_ds     = dsv;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset_stall", 32'(sbi.stall), 0);
        chk("reset_stall_ds", 32'(sbi.stall_ds), 0);
        chk("reset_wb_valid", 32'(sbi.wb_valid), 0);
        chk("reset_occ", 32'(sbi.occ), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // RAW on fs=5 right behind its producer
        set_op(1, 0, 0, 5, 0, 0, 1, 0);
        #1;
        chk("raw_producer_issue", 32'(sbi.stall), 0);
        @(negedge clk);
        set_op(1, 5, 1, 6, 1, 1, 1, 0);
        #1;
        chk("raw_c1_stall", 32'(sbi.stall), 1);
        chk("raw_c1_fwd", 32'(sbi.fwd_fs), 0);
        next_cycle();
        chk("raw_c2_stall", 32'(sbi.stall), 1);
        chk("raw_c2_fwd", 32'(sbi.fwd_fs), 0);
        next_cycle();
        chk("raw_c3_wb_valid", 32'(sbi.wb_valid), 1);
        chk("raw_c3_wb_rn", 32'(sbi.wb_rn), 5);
        chk("raw_c3_fwd_ft", 32'(sbi.fwd_ft), 0);
`ifdef FPU_SB_FWD_EN
        chk("raw_c3_stall", 32'(sbi.stall), 0);
        chk("raw_c3_fwd", 32'(sbi.fwd_fs), 1);
`else
        chk("raw_c3_stall", 32'(sbi.stall), 1);
        chk("raw_c3_fwd", 32'(sbi.fwd_fs), 0);
        next_cycle();
        chk("raw_c4_stall", 32'(sbi.stall), 0);
        chk("raw_c4_fwd", 32'(sbi.fwd_fs), 0);
`endif
        drain();

        // fdiv fd=7 followed by independent ops
        set_op(1, 0, 0, 7, 0, 0, 1, 1);
        #1;
        chk("div_issue", 32'(sbi.stall), 0);
        @(negedge clk);
        set_op(1, 1, 2, 8, 1, 1, 1, 0);
        #1;
        for (int i = 1; i <= 3; i++) begin
            chk("div_hold_stall_ds", 32'(sbi.stall_ds), 1);
            chk("div_hold_stall", 32'(sbi.stall), 1);
            chk("div_hold_occ", 32'(sbi.occ), 1);
            next_cycle();
        end
        chk("div_c4_stall_ds", 32'(sbi.stall_ds), 0);
        chk("div_c4_stall", 32'(sbi.stall), 0);
        @(negedge clk);
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("div_c5_wb_valid", 32'(sbi.wb_valid), 0);
        next_cycle();
        chk("div_c6_wb_valid", 32'(sbi.wb_valid), 1);
        chk("div_c6_wb_rn", 32'(sbi.wb_rn), 7);
        next_cycle();
        chk("div_c7_wb_rn", 32'(sbi.wb_rn), 8);
        drain();

        // fd=3 in stage 2 and stage 0: younger match wins, no forward
        set_op(1, 0, 0, 3, 0, 0, 1, 0);
        @(negedge clk);
        set_op(1, 0, 0, 9, 0, 0, 1, 0);
        @(negedge clk);
        set_op(1, 0, 0, 3, 0, 0, 1, 0);
        #1;
        chk("waw_issue", 32'(sbi.stall), 0);
        @(negedge clk);
        set_op(1, 3, 0, 12, 1, 0, 1, 0);
        #1;
        chk("dual_match_stall", 32'(sbi.stall), 1);
        chk("dual_match_fwd", 32'(sbi.fwd_fs), 0);
        chk("dual_match_occ", 32'(sbi.occ), 3);
        chk("dual_match_wb_rn", 32'(sbi.wb_rn), 3);
        drain();

        // reset in the middle of a div/sqrt hold
        set_op(1, 0, 0, 7, 0, 0, 1, 1);
        @(negedge clk);
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("rst_pre_stall_ds", 32'(sbi.stall_ds), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_occ", 32'(sbi.occ), 0);
        chk("rst_mid_stall_ds", 32'(sbi.stall_ds), 0);
        chk("rst_mid_wb_valid", 32'(sbi.wb_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_op(1, 0, 0, 4, 0, 0, 1, 1);
        #1;
        chk("rst_div_issue", 32'(sbi.stall), 0);
        @(negedge clk);
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        for (int i = 1; i <= 3; i++) begin
            chk("rst_div_hold", 32'(sbi.stall_ds), 1);
            next_cycle();
        end
        chk("rst_div_release", 32'(sbi.stall_ds), 0);
        drain();

        // back-to-back independent issues
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_op(1, 0, 0, 5'(16 + i), 0, 0, 1, 0);
            #1;
            chk("stream_stall", 32'(sbi.stall), 0);
            chk("stream_occ", 32'(sbi.occ), (i < 3) ? i : 3);
            chk("stream_wb_valid", 32'(sbi.wb_valid), (i >= 3) ? 1 : 0);
            if (i >= 3) chk("stream_wb_rn", 32'(sbi.wb_rn), 32'(16 + i - 3));
        end
        drain();
        chk("final_occ", 32'(sbi.occ), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
